fifo_rr_arbiter: RTL and testbench
==================================

// Module: fifo_rr_arbiter
// PURPOSE
//  Round-robin scheduler between 4 input FIFOs (one per traffic class) and 4 output FIFOs.
//  Pops at most one input FIFO per cycle and forwards the popped word to the output FIFO
//  selected by the word's 2 MSBs. Honours the output FIFOs' pause (flow control).
//  Also holds the almost_full/almost_empty thresholds for the FIFOs, captured in INIT.
// PARAMETERS
//  BITNUMBER  6  word width; bits [BITNUMBER-1:BITNUMBER-2] = destination index 0..3
//  LENGTH     4  FIFO depth; threshold registers are $clog2(LENGTH)+1 bits (TW)
// PORTS
//  clk             in   1              clock, all logic on posedge
//  reset           in   1              synchronous, active-high
//  init            in   1              1 = enter/stay in INIT (threshold load)
//  umbral_af       in   TW             almost-full threshold to load
//  umbral_ae       in   TW             almost-empty threshold to load
//  in_empty        in   4              Fifo_empty of input FIFOs 0..3
//  in_valid        in   4              valid_read of input FIFOs 0..3
//  in_data         in   4*BITNUMBER    Fifo_Data_out of input FIFO i at [i*BITNUMBER +: BITNUMBER]
//  out_pause       in   4              pause of output FIFOs 0..3
//  in_pop          out  4              Fifo_rd to input FIFOs, at most one bit set
//  out_push        out  4              Fifo_wr to output FIFOs, at most one bit set
//  out_data        out  BITNUMBER      Fifo_Data_in shared by all output FIFOs
//  cfg_af, cfg_ae  out  TW each        registered thresholds for the FIFOs
//  state           out  4              one-hot FSM state
//  arb_error       out  1              sticky protocol error
// BEHAVIOUR
//  Reset: state=RESET(0001); in_pop, out_push, out_data, cfg_af, cfg_ae, arb_error=0;
//   rr pointer=0; in-flight counter=0; last-popped mask=0.
//  FSM (one-hot): RESET 0001, INIT 0010, IDLE 0100, ACTIVE 1000.
//   RESET -> INIT on the first cycle with reset=0.
//   INIT: cfg_af<=umbral_af, cfg_ae<=umbral_ae every cycle; -> IDLE when init=0.
//   IDLE: -> INIT if init=1; else -> ACTIVE if any in_empty bit is 0.
//   ACTIVE: -> INIT if init=1; -> IDLE if all in_empty=1 and in-flight=0.
//   init takes priority over every other transition.
//  Pop rule (ACTIVE only): FIFO i eligible if in_empty[i]=0, out_pause=4'b0000, in-flight<3,
//   and i was not popped in the previous cycle (covers the 1-cycle-late empty flag).
//   Grant = first eligible index at or after rr pointer, searching pointer, pointer+1, ... mod 4.
//   On grant g: in_pop[g]=1 for exactly 1 cycle (registered); pointer <= (g+1) mod 4.
//   No grant: in_pop=0, pointer unchanged.
//  In-flight counter (2 bits): +1 on pop, -1 on any in_valid bit, unchanged if both in one cycle.
//  Forwarding (any state except RESET): if in_valid[i]=1 at cycle n, then at n+1
//   out_data=in_data[i], out_push[d]=1 where d=in_data[i][BITNUMBER-1:BITNUMBER-2].
//   out_push is 0 otherwise. out_data holds its last value when there is no push.
//   Data popped before entering INIT is still forwarded.
//  arb_error <= 1 (sticky until reset) if in_valid has >1 bit set, or in_valid!=0 with
//   in-flight=0. The offending word is not forwarded.
//  Reset mid-operation: all state cleared the next cycle. In-flight words are dropped.
// TESTING
//  T1 reset 2 cyc, init=1 with umbral_af=3, umbral_ae=1, then init=0 -> cfg_af=3, cfg_ae=1;
//   state 0001->0010->0100.
//  T2 only FIFO2 non-empty (3 words) -> in_pop=0100 never in consecutive cycles; 3 pops;
//   words pushed in order.
//  T3 FIFOs 0..3 all non-empty, no pause -> grants 0,1,2,3,0... in order.
//   Pointer wraps from 3 to 0.
//  T4 word 6'b10_0101 on in_valid[1] -> next cycle out_push=0100, out_data=6'b100101.
//  T5 out_pause[3]=1 while inputs are non-empty -> in_pop=0 until pause clears.
//   Words already in flight are still pushed.
//  T6 in_valid=0011, or in_valid with no pop outstanding -> arb_error=1, held until reset.
//   Also: init=1 during ACTIVE -> state=INIT, no further pops.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Round-robin pop scheduler: four class input FIFOs feed four destination output FIFOs,
// with output flow control, in-flight word tracking and FIFO threshold registers.
module fifo_rr_arbiter #(
   parameter int unsigned  BITNUMBER = 6,
   parameter int unsigned  LENGTH    = 4,
   localparam int unsigned TW        = $clog2(LENGTH) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   init,
   input  logic [TW-1:0]          umbral_af,
   input  logic [TW-1:0]          umbral_ae,
   input  logic [3:0]             in_empty,
   input  logic [3:0]             in_valid,
   input  logic [4*BITNUMBER-1:0] in_data,
   input  logic [3:0]             out_pause,
   output logic [3:0]             in_pop,
   output logic [3:0]             out_push,
   output logic [BITNUMBER-1:0]   out_data,
   output logic [TW-1:0]          cfg_af,
   output logic [TW-1:0]          cfg_ae,
   output logic [3:0]             state,
   output logic                   arb_error
);

   localparam logic [3:0] ST_RESET  = 4'b0001;
   localparam logic [3:0] ST_INIT   = 4'b0010;
   localparam logic [3:0] ST_IDLE   = 4'b0100;
   localparam logic [3:0] ST_ACTIVE = 4'b1000;
   localparam logic [1:0] MAX_FLY   = 2'd3;

   logic [3:0]           state_q, state_d;
   logic [3:0]           in_pop_q, in_pop_d;
   logic [3:0]           out_push_q, out_push_d;
   logic [BITNUMBER-1:0] out_data_q, out_data_d;
   logic [TW-1:0]        cfg_af_q, cfg_af_d;
   logic [TW-1:0]        cfg_ae_q, cfg_ae_d;
   logic                 arb_error_q, arb_error_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [1:0]           fly_q, fly_d;

   logic                 pop_ok;
   logic [3:0]           eligible;
   logic                 grant_vld;
   logic [1:0]           grant_idx;
   logic [1:0]           probe;
   logic                 valid_any;
   logic                 valid_multi;
   logic [BITNUMBER-1:0] sel_word;

   // Grant search; in_pop_q masks the FIFO whose empty flag has not caught up with last pop yet.
   always_comb begin
      pop_ok    = (state_q == ST_ACTIVE) && !init && (out_pause == 4'b0000) && (fly_q < MAX_FLY);
      eligible  = ~in_empty & ~in_pop_q & {4{pop_ok}};
      grant_vld = 1'b0;
      grant_idx = 2'd0;
      probe     = 2'd0;
      for (int k = 0; k < 4; k++) begin
         probe = rr_ptr_q + 2'(k);
         if (!grant_vld && eligible[probe]) begin
            grant_vld = 1'b1;
            grant_idx = probe;
         end
      end
   end

   // Decode the read-return strobes from the input FIFOs.
   always_comb begin
      valid_any   = |in_valid;
      valid_multi = (in_valid & (in_valid - 4'd1)) != 4'b0000;
      sel_word    = '0;
      for (int i = 0; i < 4; i++) begin
         if (in_valid[i]) sel_word = in_data[i*BITNUMBER +: BITNUMBER];
      end
   end

   always_comb begin
      state_d     = state_q;
      in_pop_d    = 4'b0000;
      out_push_d  = 4'b0000;
      out_data_d  = out_data_q;
      cfg_af_d    = cfg_af_q;
      cfg_ae_d    = cfg_ae_q;
      arb_error_d = arb_error_q;
      rr_ptr_d    = rr_ptr_q;
      fly_d       = fly_q;

      if (grant_vld) begin
         in_pop_d[grant_idx] = 1'b1;
         rr_ptr_d            = grant_idx + 2'd1;
      end

      // A return must be single and answer an outstanding pop; otherwise it is dropped.
      if (valid_multi || (valid_any && (fly_q == 2'd0))) begin
         arb_error_d = 1'b1;
      end else if (valid_any && (state_q != ST_RESET)) begin
         out_data_d                                 = sel_word;
         out_push_d[sel_word[BITNUMBER-1 -: 2]]     = 1'b1;
      end

      case ({grant_vld, valid_any && (fly_q != 2'd0)})
         2'b10:   fly_d = fly_q + 2'd1;
         2'b01:   fly_d = fly_q - 2'd1;
         default: fly_d = fly_q;
      endcase

      if (state_q == ST_INIT) begin
         cfg_af_d = umbral_af;
         cfg_ae_d = umbral_ae;
      end

      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   if (!init) state_d = ST_IDLE;
         ST_IDLE: begin
            if (init)                        state_d = ST_INIT;
            else if (in_empty != 4'b1111)    state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (init)                                   state_d = ST_INIT;
            else if ((&in_empty) && (fly_q == 2'd0))    state_d = ST_IDLE;
         end
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RESET;
         in_pop_q    <= 4'b0000;
         out_push_q  <= 4'b0000;
         out_data_q  <= '0;
         cfg_af_q    <= '0;
         cfg_ae_q    <= '0;
         arb_error_q <= 1'b0;
         rr_ptr_q    <= 2'd0;
         fly_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         in_pop_q    <= in_pop_d;
         out_push_q  <= out_push_d;
         out_data_q  <= out_data_d;
         cfg_af_q    <= cfg_af_d;
         cfg_ae_q    <= cfg_ae_d;
         arb_error_q <= arb_error_d;
         rr_ptr_q    <= rr_ptr_d;
         fly_q       <= fly_d;
      end
   end

   assign in_pop    = in_pop_q;
   assign out_push  = out_push_q;
   assign out_data  = out_data_q;
   assign cfg_af    = cfg_af_q;
   assign cfg_ae    = cfg_ae_q;
   assign state     = state_q;
   assign arb_error = arb_error_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: simple input-FIFO environment, a behavioural reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_fifo_rr_arbiter;

   localparam int BN = 6;
   localparam int TW = 3;

   logic          clk;
   logic          reset;
   logic          init;
   logic [TW-1:0] umbral_af, umbral_ae;
   logic [3:0]    in_empty, in_valid, out_pause;
   logic [4*BN-1:0] in_data;
   logic [3:0]    in_pop, out_push, state;
   logic [BN-1:0] out_data;
   logic [TW-1:0] cfg_af, cfg_ae;
   logic          arb_error;

   fifo_rr_arbiter #(.BITNUMBER(BN), .LENGTH(4)) dut (
      .clk(clk), .reset(reset), .init(init),
      .umbral_af(umbral_af), .umbral_ae(umbral_ae),
      .in_empty(in_empty), .in_valid(in_valid), .in_data(in_data),
      .out_pause(out_pause),
      .in_pop(in_pop), .out_push(out_push), .out_data(out_data),
      .cfg_af(cfg_af), .cfg_ae(cfg_ae), .state(state), .arb_error(arb_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3;
   int          m_st, m_ptr, m_fly, m_last;
   logic [3:0]  e_pop, e_push;
   logic [BN-1:0] e_data;
   logic [TW-1:0] e_af, e_ae;
   logic        e_err;
   bit          live = 1'b0;

   always @(posedge clk) begin
      int nv, src, g, nxt, c;
      logic [BN-1:0] w;
      live = 1'b1;
      if (reset) begin
         m_st = S_RESET; m_ptr = 0; m_fly = 0; m_last = -1;
         e_pop = 4'b0; e_push = 4'b0; e_data = '0; e_af = '0; e_ae = '0; e_err = 1'b0;
      end else begin
         nv  = $countones(in_valid);
         src = 0;
         for (int i = 0; i < 4; i++) if (in_valid[i]) src = i;
         w = in_data[src*BN +: BN];
         e_push = 4'b0;
         if (nv > 1 || (nv == 1 && m_fly == 0)) e_err = 1'b1;
         else if (nv == 1 && m_st != S_RESET) begin
            e_data = w;
            e_push = 4'b0001 << w[BN-1 -: 2];
         end
         g = -1;
         if (m_st == S_ACTIVE && !init && out_pause == 4'b0 && m_fly < 3) begin
            for (int k = 0; k < 4; k++) begin
               c = (m_ptr + k) % 4;
               if (g < 0 && !in_empty[c] && c != m_last) g = c;
            end
         end
         e_pop = 4'b0;
         if (g >= 0) begin
            e_pop[g] = 1'b1;
            m_ptr = (g + 1) % 4;
         end
         if (m_st == S_INIT) begin
            e_af = umbral_af;
            e_ae = umbral_ae;
         end
         case (m_st)
            S_RESET: nxt = S_INIT;
            S_INIT:  nxt = init ? S_INIT : S_IDLE;
            S_IDLE:  nxt = init ? S_INIT : ((in_empty != 4'hF) ? S_ACTIVE : S_IDLE);
            default: nxt = init ? S_INIT : ((in_empty == 4'hF && m_fly == 0) ? S_IDLE : S_ACTIVE);
         endcase
         m_fly  = m_fly + ((g >= 0) ? 1 : 0) - ((nv > 0 && m_fly > 0) ? 1 : 0);
         m_last = g;
         m_st   = nxt;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("in_pop",    32'(in_pop),    32'(e_pop));
         chk("out_push",  32'(out_push),  32'(e_push));
         chk("out_data",  32'(out_data),  32'(e_data));
         chk("cfg_af",    32'(cfg_af),    32'(e_af));
         chk("cfg_ae",    32'(cfg_ae),    32'(e_ae));
         chk("state",     32'(state),     32'(4'b0001 << m_st));
         chk("arb_error", 32'(arb_error), 32'(e_err));
      end
   end

   // ---------------- input FIFO environment ----------------
   logic [BN-1:0] fmem [4][16];
   int            fhead [4];
   int            fcnt  [4];
   logic [3:0]    cur_pop;

   task automatic load(input int i, input logic [BN-1:0] w);
      fmem[i][fhead[i] + fcnt[i]] = w;
      fcnt[i]++;
      in_empty[i] = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      in_valid = 4'b0;
      for (int i = 0; i < 4; i++) begin
         if (cur_pop[i] && fcnt[i] > 0) begin
            in_data[i*BN +: BN] = fmem[i][fhead[i]];
            in_valid[i] = 1'b1;
            fhead[i]++;
            fcnt[i]--;
         end
         in_empty[i] = (fcnt[i] == 0);
      end
      cur_pop = in_pop;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         fhead[i] = 0;
         fcnt[i]  = 0;
      end
      in_empty = 4'hF;
      in_valid = 4'b0;
      cur_pop  = 4'b0;
      reset    = 1'b0;
   endtask

   task automatic bring_up();
      init = 1'b1;
      tick();
      tick();
      init = 1'b0;
      tick();
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int pops, consec, pushes, got;
      logic prev2;
      logic [BN-1:0] t2_words [3];
      logic [BN-1:0] got2 [$];
      int seq [$];
      logic [3:0] t3_exp [8];

      reset = 1'b1; init = 1'b0; umbral_af = '0; umbral_ae = '0;
      in_empty = 4'hF; in_valid = 4'b0; in_data = '0; out_pause = 4'b0; cur_pop = 4'b0;
      for (int i = 0; i < 4; i++) begin
         fhead[i] = 0;
         fcnt[i]  = 0;
      end

      // T1: reset values, threshold load, state walk
      tick(); tick();
      chk("t1_reset_state", 32'(state), 32'h1);
      chk("t1_reset_pop",   32'(in_pop), 32'h0);
      chk("t1_reset_err",   32'(arb_error), 32'h0);
      reset = 1'b0; init = 1'b1; umbral_af = 3'd3; umbral_ae = 3'd1;
      tick();
      chk("t1_state_init", 32'(state), 32'h2);
      tick();
      init = 1'b0;
      tick();
      chk("t1_state_idle", 32'(state), 32'h4);
      chk("t1_cfg_af", 32'(cfg_af), 32'd3);
      chk("t1_cfg_ae", 32'(cfg_ae), 32'd1);

      // T2: single class, no back-to-back pops, order preserved
      t2_words[0] = 6'b01_0001; t2_words[1] = 6'b11_0010; t2_words[2] = 6'b00_0011;
      for (int i = 0; i < 3; i++) load(2, t2_words[i]);
      pops = 0; consec = 0; prev2 = 1'b0;
      repeat (14) begin
         tick();
         if (in_pop[2]) begin
            pops++;
            if (prev2) consec++;
         end
         prev2 = in_pop[2];
         if (out_push != 4'b0) got2.push_back(out_data);
      end
      chk("t2_pop_count", 32'(pops), 32'd3);
      chk("t2_consecutive", 32'(consec), 32'd0);
      chk("t2_push_count", 32'(got2.size()), 32'd3);
      for (int i = 0; i < 3 && i < got2.size(); i++)
         chk($sformatf("t2_word%0d", i), 32'(got2[i]), 32'(t2_words[i]));

      // T3: all classes busy; pointer left at 3 by T2, so order starts at 3 and wraps
      repeat (3) tick();
      load(0, 6'b00_0001); load(0, 6'b01_0010);
      load(1, 6'b10_0011); load(1, 6'b11_0100);
      load(2, 6'b01_0101); load(2, 6'b00_0110);
      load(3, 6'b11_0111); load(3, 6'b10_1000);
      t3_exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      repeat (14) begin
         tick();
         if (in_pop != 4'b0) seq.push_back(int'(in_pop));
      end
      chk("t3_grant_count", 32'(seq.size()), 32'd8);
      for (int i = 0; i < 8 && i < seq.size(); i++)
         chk($sformatf("t3_grant%0d", i), 32'(seq[i]), 32'(t3_exp[i]));

      // T4: word routed by its two MSBs
      repeat (3) tick();
      load(1, 6'b10_0101);
      got = 0;
      for (int k = 0; k < 10 && got == 0; k++) begin
         tick();
         if (out_push != 4'b0) got = 1;
      end
      chk("t4_push_seen", 32'(got), 32'd1);
      chk("t4_out_push", 32'(out_push), 32'b0100);
      chk("t4_out_data", 32'(out_data), 32'b100101);

      // T5: pause blocks pops but not the word already in flight
      repeat (3) tick();
      load(0, 6'b00_1001); load(0, 6'b01_1010);
      load(3, 6'b10_1011); load(3, 6'b11_1100);
      tick(); tick();
      chk("t5_first_pop", 32'(in_pop), 32'b1000);
      out_pause = 4'b1000;
      pushes = 0;
      repeat (6) begin
         tick();
         chk("t5_paused_pop", 32'(in_pop), 32'h0);
         if (out_push != 4'b0) pushes++;
      end
      chk("t5_inflight_pushed", 32'(pushes), 32'd1);
      out_pause = 4'b0;
      pushes = 0;
      repeat (14) begin
         tick();
         if (out_push != 4'b0) pushes++;
      end
      chk("t5_drain_pushes", 32'(pushes), 32'd3);

      // T6: protocol errors are sticky until reset
      repeat (3) tick();
      in_data  = 24'h00_0FC3;
      in_valid = 4'b0011;
      tick();
      chk("t6_multi_err", 32'(arb_error), 32'h1);
      chk("t6_multi_nopush", 32'(out_push), 32'h0);
      repeat (3) tick();
      chk("t6_sticky", 32'(arb_error), 32'h1);
      do_reset();
      chk("t6_err_cleared", 32'(arb_error), 32'h0);
      bring_up();
      in_valid = 4'b0001;
      tick();
      chk("t6_orphan_err", 32'(arb_error), 32'h1);
      do_reset();
      bring_up();

      // init raised while ACTIVE stops pops; words already popped still forwarded
      load(0, 6'b01_0001); load(0, 6'b10_0010);
      load(1, 6'b11_0011); load(1, 6'b00_0100);
      load(2, 6'b01_0101); load(2, 6'b10_0110);
      tick(); tick(); tick();
      chk("t6_active_pop", 32'(in_pop), 32'b0010);
      init = 1'b1; umbral_af = 3'd5; umbral_ae = 3'd2;
      tick();
      chk("t6_state_init", 32'(state), 32'h2);
      chk("t6_no_pop", 32'(in_pop), 32'h0);
      repeat (5) begin
         tick();
         chk("t6_init_no_pop", 32'(in_pop), 32'h0);
      end
      chk("t6_cfg_af", 32'(cfg_af), 32'd5);
      chk("t6_cfg_ae", 32'(cfg_ae), 32'd2);
      init = 1'b0;
      tick();
      chk("t6_back_idle", 32'(state), 32'h4);
      repeat (3) tick();

      // reset in the middle of traffic drops in-flight words cleanly
      do_reset();
      chk("rst_mid_state", 32'(state), 32'h1);
      chk("rst_mid_push", 32'(out_push), 32'h0);
      bring_up();
      repeat (4) tick();
      chk("rst_mid_no_err", 32'(arb_error), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
